// File: rtl/seg7_pkg.sv
// Shared segment types and glyph constants for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_MINUS = 7'b0111111;

  localparam seg_t SEG_D0 = 7'b1000000;
  localparam seg_t SEG_D1 = 7'b1111001;
  localparam seg_t SEG_D2 = 7'b0100100;
  localparam seg_t SEG_D3 = 7'b0110000;
  localparam seg_t SEG_D4 = 7'b0011001;
  localparam seg_t SEG_D5 = 7'b0010010;
  localparam seg_t SEG_D6 = 7'b0000010;
  localparam seg_t SEG_D7 = 7'b1111000;
  localparam seg_t SEG_D8 = 7'b0000000;
  localparam seg_t SEG_D9 = 7'b0010000;

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD nibble to active-low segment decoder.
// Codes 10-15 render as blank.
module seg7_bcd_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:    seg = SEG_D0;
      4'd1:    seg = SEG_D1;
      4'd2:    seg = SEG_D2;
      4'd3:    seg = SEG_D3;
      4'd4:    seg = SEG_D4;
      4'd5:    seg = SEG_D5;
      4'd6:    seg = SEG_D6;
      4'd7:    seg = SEG_D7;
      4'd8:    seg = SEG_D8;
      4'd9:    seg = SEG_D9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: NUM_DIGITS BCD digits plus one sign digit.
// Define SEG7_LZB_EN to blank leading zeros above the most significant non-zero digit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    neg_in,
  output seg_t                    seg,
  output logic [NUM_DIGITS:0]     an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS + 1);
  localparam logic [NUM_DIGITS:0] AN_ONE = 1;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic                    shadow_neg;
  logic                    tc;
  logic [3:0]              nibble;
  seg_t                    dec_seg;
  seg_t                    seg_next;
  logic                    lz_blank;

  assign tc = (cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_bcd <= '0;
      shadow_neg <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
      if (tc) idx <= (idx == IDX_W'(NUM_DIGITS)) ? '0 : idx + IDX_W'(1);
      if (load) begin
        shadow_bcd <= bcd_in;
        shadow_neg <= neg_in;
      end
    end
  end

  // Slot 0 is never blanked, so a zero magnitude still shows one digit.
  always_comb begin
    nibble   = 4'd0;
    lz_blank = 1'b0;
`ifdef SEG7_LZB_EN
    lz_blank = (idx != '0);
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) nibble = shadow_bcd[i*4 +: 4];
`ifdef SEG7_LZB_EN
      if (IDX_W'(i) >= idx && shadow_bcd[i*4 +: 4] != 4'd0) lz_blank = 1'b0;
`endif
    end
  end

  seg7_bcd_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_next = dec_seg;
    if (idx == IDX_W'(NUM_DIGITS))
      seg_next = (shadow_neg && (|shadow_bcd)) ? SEG_MINUS : SEG_BLANK;
    else if (lz_blank)
      seg_next = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= ~(AN_ONE << idx);
    end
  end

endmodule
